icache_refill_ctrl: RTL and testbench

Refill engine for the instruction cache. It is the writer that drives the cache data array's refill write port and the tag array's write port. On a miss it issues one 4-beat wrapping burst read to memory, starting at the critical word. Each returned word is written into the data array at the correct line and offset. The critical word is forwarded to the fetch stage, and the tag is validated once the line is complete.

---
 rtl/icache_refill_ctrl_if.sv | 49 ++++
 rtl/icache_refill_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle for the instruction-cache refill engine: miss request,
// memory burst read channels, data/tag array write ports, fetch forward
// and status. master = refill engine, slave = its surroundings.
interface icache_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 4
);
  logic                  miss_valid;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  miss_ready;
  logic                  ar_valid;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_ready;
  logic                  r_valid;
  logic [31:0]           r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  r_ready;
  logic                  da_we;
  logic [INDEX_BITS-1:0] da_index;
  logic [1:0]            da_offset;
  logic [31:0]           da_wdata;
  logic                  tag_we;
  logic [INDEX_BITS-1:0] tag_index;
  logic [TAG_BITS-1:0]   tag_value;
  logic                  tag_valid;
  logic                  fwd_valid;
  logic [31:0]           fwd_data;
  logic                  refill_done;
  logic                  refill_err;
  logic                  busy;

  modport master (
    input  miss_valid, miss_addr, ar_ready, r_valid, r_data, r_resp, r_last,
    output miss_ready, ar_valid, ar_addr, r_ready,
           da_we, da_index, da_offset, da_wdata,
           tag_we, tag_index, tag_value, tag_valid,
           fwd_valid, fwd_data, refill_done, refill_err, busy
  );

  modport slave (
    output miss_valid, miss_addr, ar_ready, r_valid, r_data, r_resp, r_last,
    input  miss_ready, ar_valid, ar_addr, r_ready,
           da_we, da_index, da_offset, da_wdata,
           tag_we, tag_index, tag_value, tag_valid,
           fwd_valid, fwd_data, refill_done, refill_err, busy
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill engine. Accepts a miss, issues one 4-beat
// wrapping burst starting at the critical word, writes every beat into the
// data array, forwards the critical word and finally writes the tag (valid
// only if the whole burst was clean). All outputs are registered.
module icache_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_refill_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;

  logic [TAG_BITS-1:0]   tag_r;
  logic [INDEX_BITS-1:0] index_r;
  logic [1:0]            crit_off_r;
  logic [1:0]            wr_off_r;
  logic [1:0]            beat_cnt_r;
  logic                  err_r;

  logic                  miss_ready_r;
  logic                  ar_valid_r;
  logic [ADDR_WIDTH-1:0] ar_addr_r;
  logic                  r_ready_r;
  logic                  busy_r;
  logic                  da_we_r;
  logic [INDEX_BITS-1:0] da_index_r;
  logic [1:0]            da_offset_r;
  logic [31:0]           da_wdata_r;
  logic                  fwd_valid_r;
  logic [31:0]           fwd_data_r;
  logic                  tag_we_r;
  logic [INDEX_BITS-1:0] tag_index_r;
  logic [TAG_BITS-1:0]   tag_value_r;
  logic                  tag_valid_r;
  logic                  refill_done_r;
  logic                  refill_err_r;

  logic                  miss_acc_s;
  logic                  ar_acc_s;
  logic                  beat_acc_s;
  logic                  last_beat_s;
  logic                  beat_err_s;
  logic                  err_nxt_s;
  logic                  unused_addr_lsb_s;

  // Byte-within-word bits play no part in a word-granular refill.
  assign unused_addr_lsb_s = ^bus.miss_addr[1:0];

  // Handshake decode and sticky error update for the beat being accepted.
  always_comb begin
    miss_acc_s  = bus.miss_valid & miss_ready_r;
    ar_acc_s    = ar_valid_r & bus.ar_ready;
    beat_acc_s  = bus.r_valid & r_ready_r;
    last_beat_s = beat_acc_s & (beat_cnt_r == 2'd3);
    // r_last must mark exactly the fourth beat; the beat counter decides the end.
    beat_err_s  = (bus.r_resp != 2'b00) | (bus.r_last != (beat_cnt_r == 2'd3));
    if (beat_acc_s) begin
      err_nxt_s = err_r | beat_err_s;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Next-state logic of the refill FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_acc_s) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_acc_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (last_beat_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and the state-decoded handshake outputs (registered from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      miss_ready_r <= 1'b0;
      ar_valid_r   <= 1'b0;
      r_ready_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      miss_ready_r <= (state_nxt_s == ST_IDLE);
      ar_valid_r   <= (state_nxt_s == ST_ADDR);
      r_ready_r    <= (state_nxt_s == ST_DATA);
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  // Latch the missing line's tag/index/critical offset and the burst address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r      <= '0;
      index_r    <= '0;
      crit_off_r <= 2'd0;
      ar_addr_r  <= '0;
    end else if (miss_acc_s) begin
      tag_r      <= bus.miss_addr[ADDR_WIDTH-1:INDEX_BITS+4];
      index_r    <= bus.miss_addr[INDEX_BITS+3:4];
      crit_off_r <= bus.miss_addr[3:2];
      ar_addr_r  <= {bus.miss_addr[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  // Beat bookkeeping: wrapping write offset, beat count and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_off_r   <= 2'd0;
      beat_cnt_r <= 2'd0;
      err_r      <= 1'b0;
    end else if (miss_acc_s) begin
      beat_cnt_r <= 2'd0;
      err_r      <= 1'b0;
    end else if (ar_acc_s) begin
      wr_off_r   <= crit_off_r;
    end else if (beat_acc_s) begin
      wr_off_r   <= wr_off_r + 2'd1;
      beat_cnt_r <= beat_cnt_r + 2'd1;
      err_r      <= err_nxt_s;
    end
  end

  // Data array write port: one strobe per accepted beat, fields hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_we_r     <= 1'b0;
      da_index_r  <= '0;
      da_offset_r <= 2'd0;
      da_wdata_r  <= 32'd0;
    end else begin
      da_we_r <= beat_acc_s;
      if (beat_acc_s) begin
        da_index_r  <= index_r;
        da_offset_r <= wr_off_r;
        da_wdata_r  <= bus.r_data;
      end
    end
  end

  // Critical-word forward: the first beat goes to fetch regardless of its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_r <= 1'b0;
      fwd_data_r  <= 32'd0;
    end else begin
      fwd_valid_r <= beat_acc_s & (beat_cnt_r == 2'd0);
      if (beat_acc_s && (beat_cnt_r == 2'd0)) begin
        fwd_data_r <= bus.r_data;
      end
    end
  end

  // Tag write and completion pulse, issued together with the last data write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_we_r      <= 1'b0;
      tag_index_r   <= '0;
      tag_value_r   <= '0;
      tag_valid_r   <= 1'b0;
      refill_done_r <= 1'b0;
      refill_err_r  <= 1'b0;
    end else begin
      tag_we_r      <= last_beat_s;
      refill_done_r <= last_beat_s;
      if (last_beat_s) begin
        tag_index_r  <= index_r;
        tag_value_r  <= tag_r;
        // A damaged line stays in the data array but can never hit.
        tag_valid_r  <= ~err_nxt_s;
        refill_err_r <= err_nxt_s;
      end
    end
  end

  assign bus.miss_ready  = miss_ready_r;
  assign bus.ar_valid    = ar_valid_r;
  assign bus.ar_addr     = ar_addr_r;
  assign bus.r_ready     = r_ready_r;
  assign bus.busy        = busy_r;
  assign bus.da_we       = da_we_r;
  assign bus.da_index    = da_index_r;
  assign bus.da_offset   = da_offset_r;
  assign bus.da_wdata    = da_wdata_r;
  assign bus.fwd_valid   = fwd_valid_r;
  assign bus.fwd_data    = fwd_data_r;
  assign bus.tag_we      = tag_we_r;
  assign bus.tag_index   = tag_index_r;
  assign bus.tag_value   = tag_value_r;
  assign bus.tag_valid   = tag_valid_r;
  assign bus.refill_done = refill_done_r;
  assign bus.refill_err  = refill_err_r;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: hand-computed refill scenarios
// covering aligned/critical-word misses, stalls, error beats and reset.
module tb_icache_refill_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  icache_refill_ctrl_if #(.ADDR_WIDTH(32), .INDEX_BITS(6)) bus_if ();

  icache_refill_ctrl #(.ADDR_WIDTH(32), .INDEX_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter (value seen at a negedge is that cycle's index).
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor of DUT strobes, sampled on the inactive edge.
  int          n_wr;
  int          n_fwd;
  int          n_tag;
  int          n_done;
  logic [1:0]  mon_off [8];
  logic [31:0] mon_data [8];
  logic [31:0] mon_fwd;
  logic [5:0]  mon_tag_index;
  logic [21:0] mon_tag_value;
  logic        mon_tag_valid;
  logic        mon_err;
  logic        mon_done_we;
  int          done_cyc;

  always @(negedge clk) begin
    if (bus_if.da_we) begin
      if (n_wr < 8) begin
        mon_off[n_wr]  = bus_if.da_offset;
        mon_data[n_wr] = bus_if.da_wdata;
      end
      n_wr++;
    end
    if (bus_if.fwd_valid) begin
      n_fwd++;
      mon_fwd = bus_if.fwd_data;
    end
    if (bus_if.tag_we) begin
      n_tag++;
      mon_tag_index = bus_if.tag_index;
      mon_tag_value = bus_if.tag_value;
      mon_tag_valid = bus_if.tag_valid;
    end
    if (bus_if.refill_done) begin
      n_done++;
      mon_err     = bus_if.refill_err;
      mon_done_we = bus_if.da_we;
      done_cyc    = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_wr   = 0;
    n_fwd  = 0;
    n_tag  = 0;
    n_done = 0;
  endtask

  // One refill: miss, address phase (optional stall and early beat), four
  // beats with optional gaps; abort_after < 4 pulls reset after that many beats.
  task automatic run_refill(
    input logic [31:0]       addr,
    input int                ar_dly,
    input int                gap,
    input bit                early,
    input logic [3:0][31:0]  data,
    input logic [3:0][1:0]   resp,
    input logic [3:0]        last,
    input int                abort_after,
    input logic [31:0]       exp_ar,
    input logic [5:0]        exp_index,
    input logic [21:0]       exp_tag,
    input logic [3:0][1:0]   exp_offs,
    input logic              exp_valid,
    input logic              exp_err
  );
    int t;
    int acc_cyc;
    clear_mon();
    @(negedge clk);
    bus_if.miss_valid = 1'b1;
    bus_if.miss_addr  = addr;
    t = 0;
    while (!bus_if.miss_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus_if.miss_ready) check_eq("tmo_miss_ready", bus_if.miss_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    bus_if.miss_valid = 1'b0;
    check_eq("busy_after_miss", bus_if.busy, 1'b1);
    check_eq("miss_ready_busy", bus_if.miss_ready, 1'b0);
    t = 0;
    while (!bus_if.ar_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("ar_valid", bus_if.ar_valid, 1'b1);
    check_eq("ar_addr", bus_if.ar_addr, exp_ar);
    for (int k = 0; k < ar_dly; k++) begin
      if (early) begin
        bus_if.r_valid = 1'b1;
        bus_if.r_data  = data[0];
        bus_if.r_resp  = resp[0];
        bus_if.r_last  = last[0];
      end
      check_eq("addr_no_r_ready", bus_if.r_ready, 1'b0);
      @(negedge clk);
      check_eq("ar_addr_hold", bus_if.ar_addr, exp_ar);
      check_eq("ar_valid_hold", bus_if.ar_valid, 1'b1);
    end
    bus_if.ar_ready = 1'b1;
    @(negedge clk);
    bus_if.ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < abort_after) begin
        for (int g = 0; g < gap; g++) begin
          bus_if.r_valid = 1'b0;
          @(negedge clk);
        end
        bus_if.r_valid = 1'b1;
        bus_if.r_data  = data[i];
        bus_if.r_resp  = resp[i];
        bus_if.r_last  = last[i];
        t = 0;
        while (!bus_if.r_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (!bus_if.r_ready) check_eq("tmo_r_ready", bus_if.r_ready, 1'b1);
        @(negedge clk);
      end
    end
    bus_if.r_valid = 1'b0;
    bus_if.r_last  = 1'b0;
    bus_if.r_resp  = 2'b00;
    if (abort_after < 4) begin
      rst_n = 1'b0;
      #1;
      check_eq("rst_flags", {bus_if.miss_ready, bus_if.ar_valid, bus_if.r_ready, bus_if.da_we,
                             bus_if.tag_we, bus_if.tag_valid, bus_if.fwd_valid, bus_if.refill_done,
                             bus_if.refill_err, bus_if.busy}, 10'd0);
      check_eq("rst_ar_addr", bus_if.ar_addr, 32'd0);
      check_eq("rst_da", {bus_if.da_index, bus_if.da_offset, bus_if.da_wdata}, 40'd0);
      check_eq("rst_tag", {bus_if.tag_index, bus_if.tag_value}, 28'd0);
      check_eq("rst_fwd", bus_if.fwd_data, 32'd0);
      clear_mon();
    end else begin
      t = 0;
      while (!bus_if.refill_done && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (!bus_if.refill_done) check_eq("tmo_refill_done", bus_if.refill_done, 1'b1);
      @(negedge clk);
      check_eq("da_we_count", n_wr, 4);
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("da_offset%0d", i), mon_off[i], exp_offs[i]);
        check_eq($sformatf("da_wdata%0d", i), mon_data[i], data[i]);
      end
      check_eq("fwd_count", n_fwd, 1);
      check_eq("fwd_data", mon_fwd, data[0]);
      check_eq("tag_we_count", n_tag, 1);
      check_eq("tag_index", mon_tag_index, exp_index);
      check_eq("tag_value", mon_tag_value, exp_tag);
      check_eq("tag_valid", mon_tag_valid, exp_valid);
      check_eq("done_count", n_done, 1);
      check_eq("refill_err", mon_err, exp_err);
      check_eq("last_we_with_done", mon_done_we, 1'b1);
      check_eq("done_latency", done_cyc - acc_cyc, 6 + ar_dly + 4 * gap);
      check_eq("idle_miss_ready", bus_if.miss_ready, 1'b1);
      check_eq("idle_busy", bus_if.busy, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    clear_mon();
    bus_if.miss_valid = 1'b0;
    bus_if.miss_addr  = 32'd0;
    bus_if.ar_ready   = 1'b0;
    bus_if.r_valid    = 1'b0;
    bus_if.r_data     = 32'd0;
    bus_if.r_resp     = 2'b00;
    bus_if.r_last     = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_flags", {bus_if.miss_ready, bus_if.ar_valid, bus_if.r_ready, bus_if.da_we,
                             bus_if.tag_we, bus_if.fwd_valid, bus_if.refill_done, bus_if.busy}, 8'd0);
    rst_n = 1'b1;
    #1;
    check_eq("miss_ready_at_release", bus_if.miss_ready, 1'b0);
    @(negedge clk);
    check_eq("miss_ready_after_release", bus_if.miss_ready, 1'b1);

    // Aligned miss, back-to-back beats.
    run_refill(32'h0000_1230, 0, 0, 1'b0,
               {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h00, 4'b1000, 4,
               32'h0000_1230, 6'h23, 22'h4, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, 1'b0);
    // Critical word at offset 3: writes wrap 3,0,1,2.
    run_refill(32'h0000_123C, 0, 0, 1'b0,
               {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'h00, 4'b1000, 4,
               32'h0000_123C, 6'h23, 22'h4, {2'd2, 2'd1, 2'd0, 2'd3}, 1'b1, 1'b0);
    // Stalled address phase with an early beat, gaps between beats, byte bits set.
    run_refill(32'h8000_0A4B, 3, 2, 1'b1,
               {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8'h00, 4'b1000, 4,
               32'h8000_0A48, 6'h24, 22'h200002, {2'd1, 2'd0, 2'd3, 2'd2}, 1'b1, 1'b0);
    // Error response on beat 2.
    run_refill(32'h0000_0FF4, 0, 0, 1'b0,
               {32'hD3, 32'hD2, 32'hD1, 32'hD0}, {2'b00, 2'b10, 2'b00, 2'b00}, 4'b1000, 4,
               32'h0000_0FF4, 6'h3F, 22'h3, {2'd0, 2'd3, 2'd2, 2'd1}, 1'b0, 1'b1);
    // r_last early on beat 1 at the top of the address space.
    run_refill(32'hFFFF_FFF8, 0, 0, 1'b0,
               {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 8'h00, 4'b1010, 4,
               32'hFFFF_FFF8, 6'h3F, 22'h3FFFFF, {2'd1, 2'd0, 2'd3, 2'd2}, 1'b0, 1'b1);
    // Error response on the critical beat: still forwarded.
    run_refill(32'h0000_0040, 0, 1, 1'b0,
               {32'hF3, 32'hF2, 32'hF1, 32'hF0}, {2'b00, 2'b00, 2'b00, 2'b01}, 4'b1000, 4,
               32'h0000_0040, 6'h04, 22'h0, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 1'b1);
    // r_last missing on beat 3.
    run_refill(32'h0000_0004, 0, 0, 1'b0,
               {32'h13, 32'h12, 32'h11, 32'h10}, 8'h00, 4'b0000, 4,
               32'h0000_0004, 6'h00, 22'h0, {2'd0, 2'd3, 2'd2, 2'd1}, 1'b0, 1'b1);
    // Reset after two beats.
    run_refill(32'h2000_0010, 0, 0, 1'b0,
               {32'h23, 32'h22, 32'h21, 32'h20}, 8'h00, 4'b1000, 2,
               32'h2000_0010, 6'h01, 22'h80000, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rearm_miss_ready_at_release", bus_if.miss_ready, 1'b0);
    @(negedge clk);
    check_eq("rearm_miss_ready", bus_if.miss_ready, 1'b1);
    check_eq("abort_no_tag_we", n_tag, 0);
    check_eq("abort_no_da_we", n_wr, 0);
    // Normal refill after the aborted one.
    run_refill(32'h1234_5678, 0, 0, 1'b0,
               {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0001}, 8'h00, 4'b1000, 4,
               32'h1234_5678, 6'h27, 22'h48D15, {2'd1, 2'd0, 2'd3, 2'd2}, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
